// File: rtl/cell_vector_sweeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cell_vector_sweeper : exhaustive OAI/AOI cell sweep with golden compare  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module cell_vector_sweeper #(
  parameter  int unsigned GROUP_W    = 2,
  parameter  int unsigned N_GROUPS   = 2,
  parameter  int unsigned SETTLE_CYC = 2,
  parameter  int unsigned ERR_W      = 8,
  localparam int unsigned NIN        = 1 + N_GROUPS * GROUP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  output logic [NIN-1:0]   dut_in,
  input  logic             dut_zn,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [NIN-1:0]   first_err_vec,
  output logic             first_err_valid
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam int unsigned CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST =
    CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);
  // With no settle time every vector goes straight to the compare cycle.
  localparam logic [1:0] S_NEXT_VEC = (SETTLE_CYC == 0) ? S_CHECK : S_SETTLE;

  logic [1:0]       state;
  logic [CNT_W-1:0] settle_cnt;
  logic             mode_lat;

  logic             oai_and;
  logic             aoi_or;
  logic [GROUP_W-1:0] grp;
  logic             golden;
  logic             mismatch;
  logic [ERR_W-1:0] err_inc;
  logic [ERR_W-1:0] err_next;

  // A is the MSB; each following GROUP_W-bit slice is one OR/AND group.
  always_comb begin
    oai_and = dut_in[NIN-1];
    aoi_or  = dut_in[NIN-1];
    grp     = '0;
    for (int g = 0; g < int'(N_GROUPS); g++) begin
      grp     = dut_in[int'(NIN) - 2 - g * int'(GROUP_W) -: GROUP_W];
      oai_and = oai_and & (|grp);
      aoi_or  = aoi_or  | (&grp);
    end
    golden = mode_lat ? ~aoi_or : ~oai_and;
  end

  // Case inequality so an X/Z from a broken cell counts as a mismatch in simulation.
  assign mismatch = (dut_zn !== golden);
  assign err_inc  = (err_count == {ERR_W{1'b1}}) ? err_count : err_count + 1'b1;
  assign err_next = mismatch ? err_inc : err_count;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      settle_cnt      <= '0;
      mode_lat        <= 1'b0;
      dut_in          <= '0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_err_vec   <= '0;
      first_err_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_lat        <= mode;
            dut_in          <= '0;
            err_count       <= '0;
            first_err_vec   <= '0;
            first_err_valid <= 1'b0;
            pass            <= 1'b0;
            settle_cnt      <= '0;
            state           <= S_NEXT_VEC;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          err_count <= err_next;
          if (mismatch && !first_err_valid) begin
            first_err_vec   <= dut_in;
            first_err_valid <= 1'b1;
          end
          if (dut_in == {NIN{1'b1}}) begin
            pass  <= (err_next == '0);
            state <= S_DONE;
          end else begin
            dut_in <= dut_in + 1'b1;
            state  <= S_NEXT_VEC;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cell_vector_sweeper.sv
`default_nettype none
// Directed bench: behavioural OAI221/AOI221/OAI31 cells with injectable stuck-at faults.
module tb_cell_vector_sweeper;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: default OAI221/AOI221 configuration
  logic       start_a, mode_a, zn_a, busy_a, done_a, pass_a, fevv_a;
  logic [4:0] dut_in_a, fev_a;
  logic [7:0] err_a;
  int         kind_a;   // 0=OAI221 1=AOI221 2=stuck1 3=stuck0

  // Instance B: OAI31, no settle time
  logic       start_b, mode_b, zn_b, busy_b, done_b, pass_b, fevv_b;
  logic [3:0] dut_in_b, fev_b;
  logic [7:0] err_b;
  int         kind_b;   // 0=OAI31 1=stuck1

  int total = 0;
  int bad   = 0;
  int cyc;

  cell_vector_sweeper u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a),
    .dut_in(dut_in_a), .dut_zn(zn_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .first_err_vec(fev_a),
    .first_err_valid(fevv_a)
  );

  cell_vector_sweeper #(.GROUP_W(3), .N_GROUPS(1), .SETTLE_CYC(0), .ERR_W(8)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b),
    .dut_in(dut_in_b), .dut_zn(zn_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .first_err_vec(fev_b),
    .first_err_valid(fevv_b)
  );

  always_comb begin
    case (kind_a)
      0:       zn_a = ~(dut_in_a[4] & (dut_in_a[3] | dut_in_a[2]) & (dut_in_a[1] | dut_in_a[0]));
      1:       zn_a = ~(dut_in_a[4] | (dut_in_a[3] & dut_in_a[2]) | (dut_in_a[1] & dut_in_a[0]));
      2:       zn_a = 1'b1;
      default: zn_a = 1'b0;
    endcase
    zn_b = (kind_b == 0) ? ~(dut_in_b[3] & (|dut_in_b[2:0])) : 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start pulse spans one posedge (the accept edge); returns on cycle 1 after it.
  task automatic pulse_a(input string tag);
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    cyc = 1;
    chk({tag, "_vec0"}, 32'(dut_in_a), 0);
    chk({tag, "_busy"}, 32'(busy_a), 1);
  endtask

  task automatic wait_done(input bit inst_b, input int c_in, output int c_out);
    int c = c_in;
    while (!(inst_b ? done_b : done_a) && c < 300) begin
      @(negedge clk);
      c++;
    end
    c_out = c;
  endtask

  initial begin
    rst_n = 1'b0; start_a = 0; mode_a = 0; start_b = 0; mode_b = 0;
    kind_a = 0; kind_b = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(busy_a), 0);
    chk("rst_done",  32'(done_a), 0);
    chk("rst_pass",  32'(pass_a), 0);
    chk("rst_err",   32'(err_a), 0);
    chk("rst_fev",   32'(fev_a), 0);
    chk("rst_fevv",  32'(fevv_a), 0);
    chk("rst_vec",   32'(dut_in_a), 0);
    rst_n = 1'b1;

    // 1: correct OAI221
    kind_a = 0; mode_a = 0;
    pulse_a("t1");
    wait_done(1'b0, cyc, cyc);
    chk("t1_done_cyc", 32'(cyc), 97);
    chk("t1_pass", 32'(pass_a), 1);
    chk("t1_err", 32'(err_a), 0);
    chk("t1_fevv", 32'(fevv_a), 0);
    chk("t1_busy_done", 32'(busy_a), 1);
    start_a = 1'b1;               // start in DONE cycle must be ignored
    @(negedge clk) start_a = 1'b0;
    chk("t1_idle_busy", 32'(busy_a), 0);
    chk("t1_done_pulse", 32'(done_a), 0);
    chk("t1_hold_vec", 32'(dut_in_a), 31);
    chk("t1_hold_pass", 32'(pass_a), 1);
    repeat (2) @(negedge clk);
    chk("t1_no_restart", 32'(busy_a), 0);

    // 2: stuck-at-1 vs OAI221
    kind_a = 2; mode_a = 0;
    pulse_a("t2");
    wait_done(1'b0, cyc, cyc);
    chk("t2_done_cyc", 32'(cyc), 97);
    chk("t2_err", 32'(err_a), 9);
    chk("t2_fev", 32'(fev_a), 32'b10101);
    chk("t2_fevv", 32'(fevv_a), 1);
    chk("t2_pass", 32'(pass_a), 0);

    // correct AOI221: first-error state must be cleared by start
    kind_a = 1; mode_a = 1;
    pulse_a("t3a");
    chk("t3a_clr_fevv", 32'(fevv_a), 0);
    wait_done(1'b0, cyc, cyc);
    chk("t3a_pass", 32'(pass_a), 1);
    chk("t3a_err", 32'(err_a), 0);
    chk("t3a_fev", 32'(fev_a), 0);

    // 3: stuck-at-0 vs AOI221
    kind_a = 3; mode_a = 1;
    pulse_a("t3");
    wait_done(1'b0, cyc, cyc);
    chk("t3_err", 32'(err_a), 9);
    chk("t3_fev", 32'(fev_a), 0);
    chk("t3_fevv", 32'(fevv_a), 1);
    chk("t3_pass", 32'(pass_a), 0);

    // 4: async reset mid-sweep (stuck-at-0 vs OAI so errors are already counted)
    kind_a = 3; mode_a = 0;
    pulse_a("t4");
    while (cyc < 40) begin @(negedge clk); cyc++; end
    chk("t4_pre_err", 32'(err_a != 0), 1);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", 32'(busy_a), 0);
    chk("t4_rst_done", 32'(done_a), 0);
    chk("t4_rst_vec", 32'(dut_in_a), 0);
    chk("t4_rst_err", 32'(err_a), 0);
    chk("t4_rst_fevv", 32'(fevv_a), 0);
    chk("t4_rst_pass", 32'(pass_a), 0);
    repeat (2) @(negedge clk);
    chk("t4_rst_hold", 32'(busy_a), 0);
    rst_n = 1'b1;
    kind_a = 0;
    pulse_a("t4r");
    wait_done(1'b0, cyc, cyc);
    chk("t4r_done_cyc", 32'(cyc), 97);
    chk("t4r_pass", 32'(pass_a), 1);

    // 5: re-pulse start and flip mode mid-sweep
    kind_a = 0; mode_a = 0;
    pulse_a("t5");
    while (cyc < 20) begin @(negedge clk); cyc++; end
    start_a = 1'b1; mode_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    cyc++;
    chk("t5_vec_mid", 32'(dut_in_a != 0), 1);
    wait_done(1'b0, cyc, cyc);
    chk("t5_done_cyc", 32'(cyc), 97);
    chk("t5_pass", 32'(pass_a), 1);
    chk("t5_err", 32'(err_a), 0);
    mode_a = 1'b0;

    // 6: OAI31 with no settle time
    kind_b = 0;
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    cyc = 1;
    wait_done(1'b1, cyc, cyc);
    chk("t6_done_cyc", 32'(cyc), 17);
    chk("t6_pass", 32'(pass_b), 1);
    kind_b = 1;
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    cyc = 1;
    wait_done(1'b1, cyc, cyc);
    chk("t6s_done_cyc", 32'(cyc), 17);
    chk("t6s_err", 32'(err_b), 7);
    chk("t6s_fev", 32'(fev_b), 9);
    chk("t6s_pass", 32'(pass_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
